// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default widths and a majority helper.
// Used by both the receive and transmit sides.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF = 8;
    localparam int unsigned CNT_W_DEF     = 16;

    // One-hot receiver/transmitter states
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_DATA  = 4'b0100,
        S_STOP  = 4'b1000
    } uart_state_e;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input resynchroniser for the asynchronous rx line; flops reset to the idle level (1).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic rx_i,
    output logic rx_s_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line through the flop chain
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: resynchronises rx_i, validates the start bit at its centre, samples
// data bits LSB first at bit centres and reports each byte with a one-cycle done tick.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority vote at each sample point).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 rx_en_i,
    input  logic [CNT_W-1:0]     baud_div,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 rx_done_tick_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 rx_s;
    logic                 rx_q;
    logic                 sample;
    logic [CNT_W-1:0]     half_m1;
    logic [CNT_W-1:0]     full_m1;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .rx_i   (rx_i),
        .rx_s_o (rx_s)
    );

    // One-cycle delayed copy of the synchronised line for falling-edge detection
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_q <= 1'b1;
        end else begin
            rx_q <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Two previous synchronised samples; together with rx_s they form the voting window
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample = maj3(rx_s, hist_q[0], hist_q[1]);
`else
    assign sample = rx_s;
`endif

    // Compare points; >= keeps the FSM moving if baud_div shrinks mid-frame
    assign half_m1 = (baud_div >> 1) - CNT_W'(1);
    assign full_m1 = baud_div - CNT_W'(1);

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: start detect, bit-centre sampling, stop-bit check
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_en_i && rx_q && !rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q >= half_m1) begin
                    if (!sample) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        // Line back high at mid start bit: glitch, not a frame
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q >= full_m1) begin
                    shreg_d   = {sample, shreg_q[DATA_BITS-1:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q >= full_m1) begin
                    if (sample) begin
                        dout_d = shreg_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    // Leaving at mid-stop lets a back-to-back start edge be seen
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable aborts any frame in progress without reporting it
        if (!rx_en_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            dout_d  = dout_q;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    assign dout_o         = dout_q;
    assign rx_done_tick_o = done_q;
    assign frame_err_o    = err_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
